imem_run_controller: RTL and testbench

- Synthesizable, parametrised successor to the bench-side instruction store and NOP-run terminator of the MIPS core.
- Holds a byte-addressed, big-endian instruction memory that can be loaded word-by-word, and serves fetches from the core's PC.
- Runs a control FSM that releases the core, counts cycles, and declares completion after NOP_LIMIT consecutive NOP fetches, or a timeout after TIMEOUT cycles.
- Sits between the test harness/loader and the `main` core.

---
 rtl/imem_run_controller.sv | 135 +++++++++++++
 tb/tb_imem_run_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_run_controller.sv
// Byte-addressed big-endian instruction store with a run controller that releases
// the core, counts RUN cycles and ends the run on a NOP streak or a timeout.
module imem_run_controller #(
  parameter int ADDR_W    = 8,
  parameter int NOP_LIMIT = 4,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              core_run,
  output logic              done,
  output logic              timed_out,
  output logic              addr_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [3:0]        nop_cnt,
  output logic [1:0]        fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0] mem [DEPTH];

  logic [ADDR_W-1:0] la0, la1, la2, la3;
  logic [ADDR_W-1:0] pa0, pa1, pa2, pa3;
  logic              out_of_range;
  logic              load_ok;

  logic [CNT_W-1:0]  cnt_next;
  logic [3:0]        nop_next;
  logic              done_next;
  logic              to_next;
  logic              err_next;

  // Byte offsets wrap naturally at the memory depth.
  assign la0 = load_addr;
  assign la1 = load_addr + ADDR_W'(1);
  assign la2 = load_addr + ADDR_W'(2);
  assign la3 = load_addr + ADDR_W'(3);

  assign pa0 = pc[ADDR_W-1:0];
  assign pa1 = pa0 + ADDR_W'(1);
  assign pa2 = pa0 + ADDR_W'(2);
  assign pa3 = pa0 + ADDR_W'(3);

  assign out_of_range = (pc >> ADDR_W) != 32'd0;
  assign instr        = out_of_range ? 32'h0 : {mem[pa0], mem[pa1], mem[pa2], mem[pa3]};
  assign load_ok      = load_en && (state != ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (load_ok) begin
      mem[la0] <= load_data[31:24];
      mem[la1] <= load_data[23:16];
      mem[la2] <= load_data[15:8];
      mem[la3] <= load_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cycle_count;
    nop_next   = nop_cnt;
    done_next  = done;
    to_next    = timed_out;
    err_next   = addr_err;
    case (state)
      ST_RUN: begin
        cnt_next = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        if (instr == 32'h0) nop_next = (nop_cnt == 4'hF) ? nop_cnt : nop_cnt + 4'd1;
        else                nop_next = 4'd0;
        err_next = addr_err | out_of_range;
        // NOP completion takes priority when both limits land on the same edge.
        if (nop_next == 4'(NOP_LIMIT)) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (cnt_next == CNT_W'(TIMEOUT)) begin
          state_next = ST_TIMEOUT;
          to_next    = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          nop_next   = 4'd0;
          done_next  = 1'b0;
          to_next    = 1'b0;
          err_next   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      nop_cnt     <= 4'd0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      cycle_count <= cnt_next;
      nop_cnt     <= nop_next;
      done        <= done_next;
      timed_out   <= to_next;
      addr_err    <= err_next;
    end
  end

  assign core_run  = (state == ST_RUN);
  assign fsm_state = state;

endmodule

// File: tb/tb_imem_run_controller.sv
// Bench for imem_run_controller: fetch vector table, scoreboarded checks and
// hand-written run sequences (NOP end, timeout, tie, out-of-range, mid-run reset).
module tb_imem_run_controller;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic [31:0]       pc;

  logic [31:0]      instr, t_instr;
  logic             core_run, t_core_run;
  logic             done, t_done;
  logic             timed_out, t_timed_out;
  logic             addr_err, t_addr_err;
  logic [CNT_W-1:0] cycle_count, t_cycle_count;
  logic [3:0]       nop_cnt, t_nop_cnt;
  logic [1:0]       fsm_state, t_fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  imem_run_controller #(.ADDR_W(ADDR_W), .NOP_LIMIT(4), .TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .pc(pc), .instr(instr),
    .core_run(core_run), .done(done), .timed_out(timed_out), .addr_err(addr_err),
    .cycle_count(cycle_count), .nop_cnt(nop_cnt), .fsm_state(fsm_state)
  );

  // Second instance with TIMEOUT=6 so both run-ending conditions coincide.
  imem_run_controller #(.ADDR_W(ADDR_W), .NOP_LIMIT(4), .TIMEOUT(6), .CNT_W(CNT_W)) dut_t (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .pc(pc), .instr(t_instr),
    .core_run(t_core_run), .done(t_done), .timed_out(t_timed_out), .addr_err(t_addr_err),
    .cycle_count(t_cycle_count), .nop_cnt(t_nop_cnt), .fsm_state(t_fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // Scoreboard compare: expected value comes from the front of exp_q.
  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, no expected value queued", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
    end
  endtask

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    check(name, act);
  endtask

  // Simple core model: starts a run, then fetches sequentially while core_run is high.
  task automatic run_core(input int budget, output int run_cycles);
    pc    = 32'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_cycles = 0;
    while (core_run && run_cycles < budget) begin
      run_cycles++;
      step();
      pc = pc + 32'd4;
    end
    if (core_run) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_budget: core_run still high after %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
    string       name;
  } fetch_vec_t;

  fetch_vec_t vecs[7];
  int run_cycles;

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; pc = 32'h0;
    #12;
    reset = 1'b1;
    step();

    // Reset state
    expect_val("rst_core_run", {31'd0, core_run}, 32'd0);
    expect_val("rst_done", {31'd0, done}, 32'd0);
    expect_val("rst_timed_out", {31'd0, timed_out}, 32'd0);
    expect_val("rst_addr_err", {31'd0, addr_err}, 32'd0);
    expect_val("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    expect_val("rst_nop_cnt", {28'd0, nop_cnt}, 32'd0);
    expect_val("rst_instr", instr, 32'h0);

    // Fetch table
    load_word(8'd0, 32'h200A000A);
    load_word(8'd4, 32'h200C000B);
    vecs[0] = '{32'h0000_0000, 32'h200A000A, "fetch_pc0"};
    vecs[1] = '{32'h0000_0005, 32'h0C000B00, "fetch_pc5"};
    vecs[2] = '{32'h0000_00FE, 32'h0000200A, "fetch_pc254_wrap"};
    vecs[3] = '{32'h0000_0002, 32'h000A200C, "fetch_pc2"};
    vecs[4] = '{32'h0000_0004, 32'h200C000B, "fetch_pc4"};
    vecs[5] = '{32'h0000_0100, 32'h00000000, "fetch_oor_low"};
    vecs[6] = '{32'h8000_0004, 32'h00000000, "fetch_oor_high"};
    for (int i = 0; i < 7; i++) begin
      pc = vecs[i].pc;
      exp_q.push_back(vecs[i].exp);
      #1;
      check(vecs[i].name, instr);
    end
    expect_val("idle_addr_err", {31'd0, addr_err}, 32'd0);

    // Wrapping write at the top of memory
    load_word(8'd254, 32'h11223344);
    pc = 32'h0; #1;
    expect_val("wrap_write_pc0", instr, 32'h3344000A);
    pc = 32'hFE; #1;
    expect_val("wrap_write_pc254", instr, 32'h11223344);

    // NOP-run completion, and the tie case on the TIMEOUT=6 instance
    apply_reset();
    load_word(8'd0, 32'h200A000A);
    load_word(8'd4, 32'h200C000B);
    run_core(40, run_cycles);
    expect_val("nop_run_cycles", run_cycles, 32'd6);
    expect_val("nop_done", {31'd0, done}, 32'd1);
    expect_val("nop_timed_out", {31'd0, timed_out}, 32'd0);
    expect_val("nop_cycle_count", {16'd0, cycle_count}, 32'd6);
    expect_val("nop_nop_cnt", {28'd0, nop_cnt}, 32'd4);
    expect_val("tie_done", {31'd0, t_done}, 32'd1);
    expect_val("tie_timed_out", {31'd0, t_timed_out}, 32'd0);
    expect_val("tie_cycle_count", {16'd0, t_cycle_count}, 32'd6);
    step();
    expect_val("done_holds", {31'd0, done}, 32'd1);
    expect_val("count_holds", {16'd0, cycle_count}, 32'd6);

    // Timeout with memory full of non-NOPs
    for (int w = 0; w < 64; w++) load_word(8'(w * 4), 32'h20000000);
    run_core(40, run_cycles);
    expect_val("to_run_cycles", run_cycles, 32'd16);
    expect_val("to_timed_out", {31'd0, timed_out}, 32'd1);
    expect_val("to_done", {31'd0, done}, 32'd0);
    expect_val("to_cycle_count", {16'd0, cycle_count}, 32'd16);
    expect_val("to_nop_cnt", {28'd0, nop_cnt}, 32'd0);

    // Out-of-range fetch and load attempt during RUN
    apply_reset();
    load_word(8'd0, 32'h200A000A);
    load_word(8'd4, 32'h200C000B);
    pc = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    pc = 32'h100;
    step();
    expect_val("oor_instr", instr, 32'h0);
    expect_val("oor_addr_err", {31'd0, addr_err}, 32'd1);
    expect_val("oor_nop_cnt", {28'd0, nop_cnt}, 32'd1);
    pc = 32'h0;
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    expect_val("run_load_ignored", instr, 32'h200A000A);
    expect_val("addr_err_sticky", {31'd0, addr_err}, 32'd1);
    expect_val("nonnop_clears_nop", {28'd0, nop_cnt}, 32'd0);
    pc = 32'h100;
    for (int k = 0; k < 10 && core_run; k++) step();
    expect_val("oor_done", {31'd0, done}, 32'd1);
    expect_val("oor_cycle_count", {16'd0, cycle_count}, 32'd6);
    expect_val("err_held_in_done", {31'd0, addr_err}, 32'd1);
    pc = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    expect_val("restart_clears_err", {31'd0, addr_err}, 32'd0);
    expect_val("restart_clears_done", {31'd0, done}, 32'd0);
    expect_val("restart_core_run", {31'd0, core_run}, 32'd1);
    step();
    expect_val("restart_count1", {16'd0, cycle_count}, 32'd1);

    // Reset mid-run, then a clean restart
    apply_reset();
    load_word(8'd0, 32'h200A000A);
    load_word(8'd4, 32'h200C000B);
    pc = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    expect_val("pre_abort_count", {16'd0, cycle_count}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    expect_val("abort_core_run", {31'd0, core_run}, 32'd0);
    expect_val("abort_cycle_count", {16'd0, cycle_count}, 32'd0);
    expect_val("abort_done", {31'd0, done}, 32'd0);
    expect_val("abort_mem_zero", instr, 32'h0);
    step();
    reset = 1'b1;
    step();
    load_word(8'd0, 32'h200A000A);
    load_word(8'd4, 32'h200C000B);
    run_core(40, run_cycles);
    expect_val("rerun_cycles", run_cycles, 32'd6);
    expect_val("rerun_done", {31'd0, done}, 32'd1);
    expect_val("rerun_cycle_count", {16'd0, cycle_count}, 32'd6);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
